// File: rtl/usb_pkg.sv
// usb_pkg -- constants and types shared by the USB transmit control slice.
//
// Contents:
//   PKT_*        TX_PACKET request encodings
//   SYNC_BYTE,
//   PID_*        bytes in wire order (bit 7 is sent first)
//   MAX_PAYLOAD  largest data payload accepted, in bytes
//   CRC16_*      data CRC polynomial and seed
//   tx_state_t   transmit sequencer states
//   crc16_next   one bit step of the data CRC
package usb_pkg;

  localparam logic [2:0] PKT_IDLE  = 3'd0;
  localparam logic [2:0] PKT_DATA  = 3'd1;
  localparam logic [2:0] PKT_ACK   = 3'd4;
  localparam logic [2:0] PKT_NAK   = 3'd5;
  localparam logic [2:0] PKT_STALL = 3'd7;

  localparam logic [7:0] SYNC_BYTE = 8'b0000_0001;
  localparam logic [7:0] PID_ACK   = 8'b0010_1101;
  localparam logic [7:0] PID_NAK   = 8'b1010_0101;
  localparam logic [7:0] PID_STALL = 8'b1110_0001;
  localparam logic [7:0] PID_DATA0 = 8'b0011_1100;
  localparam logic [7:0] PID_DATA1 = 8'b1011_0100;

  localparam logic [6:0] MAX_PAYLOAD = 7'd64;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_HI,
    ST_CRC_LO,
    ST_EOP1,
    ST_EOP2,
    ST_IDLE_J
  } tx_state_t;

  // Shift one serial bit into the CRC, MSB-first feedback.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/tx_crc16.sv
// tx_crc16 -- serial CRC16 accumulator for the transmit data field.
//
// Ports:
//   clk     in   system clock, rising edge
//   n_rst   in   asynchronous active-low reset, seeds the CRC
//   clear   in   reseed to 0xFFFF (start of a packet)
//   shift   in   absorb bit_in this cycle
//   bit_in  in   serial data bit, in wire order
//   crc     out  running CRC remainder (not complemented)
module tx_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        shift,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (shift) begin
      crc <= crc16_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/tx_control_fsm.sv
// tx_control_fsm -- USB packet transmit sequencer.
//
// Serialises SYNC, PID, optional data payload with CRC16, EOP and a trailing
// J bit, one bit per bit_strobe, MSB of every byte first.
//
// Ports:
//   clk                 in   system clock, rising edge
//   n_rst               in   asynchronous active-low reset
//   tx_start            in   one-cycle send request (honoured only when idle)
//   TX_PACKET[2:0]      in   0 idle, 1 data, 4 ACK, 5 NAK, 7 STALL
//   bit_strobe          in   one pulse per bit time, gated by the bit stuffer
//   tx_data[7:0]        in   head byte of the TX buffer
//   buffer_occupancy    in   bytes queued (max 64 accepted)
//   clear_toggle        in   force the next data PID to DATA0
//   d_bit               out  NRZ bit to the line encoder
//   eop_out             out  drive SE0
//   tx_active           out  packet in progress
//   get_tx_packet_data  out  one-cycle pop of the TX buffer
//   tx_error            out  one-cycle pulse when a request is refused
//
// Build option: define TX_STALL_EN to allow STALL handshakes; otherwise a
// STALL request is refused with tx_error.
module tx_control_fsm
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [2:0] TX_PACKET,
  input  logic       bit_strobe,
  input  logic [7:0] tx_data,
  input  logic [6:0] buffer_occupancy,
  input  logic       clear_toggle,
  output logic       d_bit,
  output logic       eop_out,
  output logic       tx_active,
  output logic       get_tx_packet_data,
  output logic       tx_error
);

`ifdef TX_STALL_EN
  localparam logic STALL_EN = 1'b1;
`else
  localparam logic STALL_EN = 1'b0;
`endif

  tx_state_t   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  pkt_q;
  logic [6:0]  bytes_left_q, bytes_left_d;
  logic        toggle_q;
  logic        tx_error_q;
  logic [7:0]  shreg_q, shreg_d;

  logic        idle_req, req_ok, start_ok, start_bad;
  logic        is_data, in_byte_state, byte_end;
  logic        load_data, toggle_flip, crc_shift;
  logic [7:0]  pid_byte;
  logic [15:0] crc;
  logic [7:0]  crc_hi, crc_lo;

  assign crc_hi = crc[15:8];
  assign crc_lo = crc[7:0];

  // Request qualification: only while idle and for a non-idle type.
  assign idle_req = (state_q == ST_IDLE) && tx_start && (TX_PACKET != PKT_IDLE);

  always_comb begin
    req_ok = 1'b0;
    case (TX_PACKET)
      PKT_DATA:  req_ok = (buffer_occupancy <= MAX_PAYLOAD);
      PKT_ACK:   req_ok = 1'b1;
      PKT_NAK:   req_ok = 1'b1;
      PKT_STALL: req_ok = STALL_EN;
      default:   req_ok = 1'b0;
    endcase
  end

  assign start_ok  = idle_req &  req_ok;
  assign start_bad = idle_req & ~req_ok;

  assign is_data       = (pkt_q == PKT_DATA);
  assign in_byte_state = (state_q == ST_SYNC)   || (state_q == ST_PID) ||
                         (state_q == ST_DATA)   || (state_q == ST_CRC_HI) ||
                         (state_q == ST_CRC_LO);
  assign byte_end      = bit_strobe && (bit_cnt_q == 3'd7);

  // The data PID is chosen when SYNC finishes, so a clear_toggle that lands
  // during SYNC still takes effect on this packet.
  always_comb begin
    pid_byte = PID_ACK;
    case (pkt_q)
      PKT_ACK:   pid_byte = PID_ACK;
      PKT_NAK:   pid_byte = PID_NAK;
      PKT_STALL: pid_byte = PID_STALL;
      PKT_DATA:  pid_byte = toggle_q ? PID_DATA1 : PID_DATA0;
      default:   pid_byte = PID_ACK;
    endcase
  end

  // Next state, shifter and byte accounting.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    bytes_left_d = bytes_left_q;
    load_data    = 1'b0;
    toggle_flip  = 1'b0;
    crc_shift    = 1'b0;

    if (bit_strobe && in_byte_state) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shreg_d   = {shreg_q[6:0], 1'b0};
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d      = ST_SYNC;
          shreg_d      = SYNC_BYTE;
          bit_cnt_d    = 3'd0;
          bytes_left_d = buffer_occupancy;
        end
      end
      ST_SYNC: begin
        if (byte_end) begin
          state_d = ST_PID;
          shreg_d = pid_byte;
        end
      end
      ST_PID: begin
        if (byte_end) begin
          if (!is_data) begin
            state_d = ST_EOP1;
          end else if (bytes_left_q != 7'd0) begin
            state_d   = ST_DATA;
            load_data = 1'b1;
          end else begin
            state_d = ST_CRC_HI;
          end
        end
      end
      ST_DATA: begin
        // The bit leaving the shifter at this strobe is the bit just sent.
        crc_shift = bit_strobe;
        if (byte_end) begin
          if (bytes_left_q != 7'd0) begin
            load_data = 1'b1;
          end else begin
            state_d = ST_CRC_HI;
          end
        end
      end
      ST_CRC_HI: if (byte_end) state_d = ST_CRC_LO;
      ST_CRC_LO: if (byte_end) state_d = ST_EOP1;
      ST_EOP1:   if (bit_strobe) state_d = ST_EOP2;
      ST_EOP2:   if (bit_strobe) state_d = ST_IDLE_J;
      ST_IDLE_J: begin
        if (bit_strobe) begin
          state_d     = ST_IDLE;
          toggle_flip = is_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_data) begin
      shreg_d      = tx_data;
      bytes_left_d = bytes_left_q - 7'd1;
    end
  end

  // Line outputs. CRC bits come straight from the frozen CRC register, so
  // the last data bit is already folded in when CRC_HI starts.
  // For a 3-bit count, ~bit_cnt_q == 7 - bit_cnt_q (MSB first).
  always_comb begin
    d_bit   = 1'b1;
    eop_out = 1'b0;
    case (state_q)
      ST_SYNC, ST_PID, ST_DATA: d_bit = shreg_q[7];
      ST_CRC_HI:                d_bit = ~crc_hi[~bit_cnt_q];
      ST_CRC_LO:                d_bit = ~crc_lo[~bit_cnt_q];
      ST_EOP1, ST_EOP2: begin
        d_bit   = 1'b0;
        eop_out = 1'b1;
      end
      default: d_bit = 1'b1;
    endcase
  end

  assign tx_active          = (state_q != ST_IDLE);
  assign get_tx_packet_data = load_data;
  assign tx_error           = tx_error_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      pkt_q        <= PKT_IDLE;
      bytes_left_q <= 7'd0;
      toggle_q     <= 1'b0;
      tx_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bytes_left_q <= bytes_left_d;
      tx_error_q   <= start_bad;
      if (start_ok) begin
        pkt_q <= TX_PACKET;
      end
      // clear_toggle outranks the end-of-packet inversion.
      if (clear_toggle) begin
        toggle_q <= 1'b0;
      end else if (toggle_flip) begin
        toggle_q <= ~toggle_q;
      end
    end
  end

  // Payload shifter carries data only; d_bit ignores it outside byte states.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  tx_crc16 u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (start_ok),
    .shift  (crc_shift),
    .bit_in (shreg_q[7]),
    .crc    (crc)
  );

endmodule

// File: tb/tb_tx_control_fsm.sv
// tb_tx_control_fsm -- directed bench for tx_control_fsm with a wire-bit
// scoreboard: each request pushes its expected bit stream, and every
// bit_strobe pops one entry and compares the DUT outputs against it.
module tb_tx_control_fsm;

  logic       clk;
  logic       n_rst;
  logic       tx_start;
  logic [2:0] TX_PACKET;
  logic       bit_strobe;
  logic [7:0] tx_data;
  logic [6:0] buffer_occupancy;
  logic       clear_toggle;
  logic       d_bit;
  logic       eop_out;
  logic       tx_active;
  logic       get_tx_packet_data;
  logic       tx_error;

  tx_control_fsm dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_start           (tx_start),
    .TX_PACKET          (TX_PACKET),
    .bit_strobe         (bit_strobe),
    .tx_data            (tx_data),
    .buffer_occupancy   (buffer_occupancy),
    .clear_toggle       (clear_toggle),
    .d_bit              (d_bit),
    .eop_out            (eop_out),
    .tx_active          (tx_active),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_error           (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic d;
    logic eop;
    logic chk_d;
    logic get;
  } sym_t;

  sym_t       exp_q[$];
  logic [7:0] buf_q[$];
  logic [7:0] pkt_bytes[$];
  logic       exp_toggle;
  int         n_asserts;
  int         n_fail;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_packet();
    buf_q.delete();
    pkt_bytes.delete();
    tx_data = 8'h00;
  endtask

  task automatic add_byte(input logic [7:0] b);
    buf_q.push_back(b);
    pkt_bytes.push_back(b);
    tx_data = buf_q[0];
  endtask

  // Reference CRC16: poly 0x8005, seed 0xFFFF, data bits MSB first.
  function automatic logic [15:0] ref_crc();
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    foreach (pkt_bytes[i]) begin
      b = pkt_bytes[i];
      for (int k = 7; k >= 0; k--) begin
        if (c[15] ^ b[k]) c = {c[14:0], 1'b0} ^ 16'h8005;
        else              c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] b, input logic get_last);
    sym_t s;
    for (int i = 7; i >= 0; i--) begin
      s.d     = b[i];
      s.eop   = 1'b0;
      s.chk_d = 1'b1;
      s.get   = (i == 0) ? get_last : 1'b0;
      exp_q.push_back(s);
    end
  endtask

  task automatic expect_packet(input logic [2:0] pkt);
    logic [7:0]  pid;
    logic [15:0] c;
    sym_t        s;
    int          n;
    n = pkt_bytes.size();
    case (pkt)
      3'd4:    pid = 8'b0010_1101;
      3'd5:    pid = 8'b1010_0101;
      3'd7:    pid = 8'b1110_0001;
      default: pid = exp_toggle ? 8'b1011_0100 : 8'b0011_1100;
    endcase
    push_byte(8'b0000_0001, 1'b0);
    push_byte(pid, (pkt == 3'd1) && (n > 0));
    if (pkt == 3'd1) begin
      for (int i = 0; i < n; i++) push_byte(pkt_bytes[i], i < n - 1);
      c = ~ref_crc();
      push_byte(c[15:8], 1'b0);
      push_byte(c[7:0], 1'b0);
    end
    s.d = 1'b0; s.eop = 1'b1; s.chk_d = 1'b0; s.get = 1'b0;
    exp_q.push_back(s);
    exp_q.push_back(s);
    s.d = 1'b1; s.eop = 1'b0; s.chk_d = 1'b1;
    exp_q.push_back(s);
  endtask

  task automatic request(input logic [2:0] pkt, input logic [6:0] occ);
    tx_start         = 1'b1;
    TX_PACKET        = pkt;
    buffer_occupancy = occ;
    tick();
    tx_start = 1'b0;
  endtask

  // One bit time is 8 clocks with the strobe on the last one.
  task automatic drain(input int max_bits, input int poke_bit, input bit clr_last);
    sym_t s;
    logic got;
    int   nb;
    nb = 0;
    while (exp_q.size() > 0 && nb < max_bits) begin
      for (int t = 0; t < 7; t++) begin
        if (t == 1 && nb == poke_bit) begin
          tx_start  = 1'b1;
          TX_PACKET = 3'd1;
        end
        tick();
        tx_start = 1'b0;
        if (t == 1 && nb == poke_bit) begin
          check("busy_start_err", tx_error, 1'b0);
          check("busy_start_active", tx_active, 1'b1);
        end
        if (t == 3) begin
          if (exp_q[0].chk_d) check("d_bit_hold", d_bit, exp_q[0].d);
          check("get_no_strobe", get_tx_packet_data, 1'b0);
        end
      end
      s = exp_q.pop_front();
      bit_strobe = 1'b1;
      if (clr_last && exp_q.size() == 0) clear_toggle = 1'b1;
      #1;
      if (s.chk_d) check("d_bit", d_bit, s.d);
      check("eop_out", eop_out, s.eop);
      check("get_pulse", get_tx_packet_data, s.get);
      check("tx_active", tx_active, 1'b1);
      got = get_tx_packet_data;
      @(posedge clk);
      #1;
      bit_strobe   = 1'b0;
      clear_toggle = 1'b0;
      if (got && buf_q.size() > 0) begin
        void'(buf_q.pop_front());
        tx_data = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
      end
      nb++;
    end
    if (exp_q.size() == 0) begin
      check("end_active", tx_active, 1'b0);
      check("end_d_bit", d_bit, 1'b1);
      check("end_eop", eop_out, 1'b0);
      check("end_buf_left", buf_q.size(), 0);
    end
  endtask

  task automatic send(input logic [2:0] pkt, input int poke_bit, input bit clr_last);
    request(pkt, pkt_bytes.size());
    check("start_active", tx_active, 1'b1);
    check("start_err", tx_error, 1'b0);
    expect_packet(pkt);
    drain(1000, poke_bit, clr_last);
  endtask

  task automatic expect_reject(input logic [2:0] pkt, input logic [6:0] occ);
    request(pkt, occ);
    check("rej_err_pulse", tx_error, 1'b1);
    check("rej_active", tx_active, 1'b0);
    check("rej_d_bit", d_bit, 1'b1);
    tick();
    check("rej_err_clear", tx_error, 1'b0);
    check("rej_d_bit_after", d_bit, 1'b1);
    check("rej_active_after", tx_active, 1'b0);
  endtask

  initial begin
    n_asserts        = 0;
    n_fail           = 0;
    exp_toggle       = 1'b0;
    n_rst            = 1'b0;
    tx_start         = 1'b0;
    TX_PACKET        = 3'd0;
    bit_strobe       = 1'b0;
    tx_data          = 8'h00;
    buffer_occupancy = 7'd0;
    clear_toggle     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_d_bit", d_bit, 1'b1);
    check("rst_eop", eop_out, 1'b0);
    check("rst_active", tx_active, 1'b0);
    check("rst_get", get_tx_packet_data, 1'b0);
    check("rst_err", tx_error, 1'b0);
    n_rst = 1'b1;
    tick();

    // ACK handshake: 19 bit times
    new_packet();
    send(3'd4, -1, 1'b0);

    // Empty data packet: DATA0, all-zero CRC bits
    new_packet();
    send(3'd1, -1, 1'b0);
    exp_toggle = ~exp_toggle;

    // Two bytes, DATA1
    new_packet();
    add_byte(8'h00);
    add_byte(8'hFF);
    send(3'd1, -1, 1'b0);
    exp_toggle = ~exp_toggle;

    // Oversize payload refused
    new_packet();
    expect_reject(3'd1, 7'd65);

    // NAK with a tx_start poked mid-packet
    new_packet();
    send(3'd5, 5, 1'b0);

    // clear_toggle on the final strobe beats the inversion
    new_packet();
    add_byte(8'hA5);
    send(3'd1, -1, 1'b1);
    exp_toggle = 1'b0;

    new_packet();
    add_byte(8'h3C);
    add_byte(8'h81);
    add_byte(8'h7E);
    send(3'd1, -1, 1'b0);
    exp_toggle = ~exp_toggle;

    // clear_toggle while idle
    clear_toggle = 1'b1;
    tick();
    clear_toggle = 1'b0;
    exp_toggle   = 1'b0;
    new_packet();
    send(3'd1, -1, 1'b0);
    exp_toggle = ~exp_toggle;

    // Reset while in the DATA state
    new_packet();
    add_byte(8'h12);
    add_byte(8'h34);
    request(3'd1, 7'd2);
    expect_packet(3'd1);
    drain(20, -1, 1'b0);
    n_rst = 1'b0;
    #1;
    check("midrst_d_bit", d_bit, 1'b1);
    check("midrst_eop", eop_out, 1'b0);
    check("midrst_active", tx_active, 1'b0);
    check("midrst_get", get_tx_packet_data, 1'b0);
    tick();
    tick();
    n_rst = 1'b1;
    exp_q.delete();
    exp_toggle = 1'b0;
    tick();
    check("postrst_d_bit", d_bit, 1'b1);
    check("postrst_active", tx_active, 1'b0);
    new_packet();
    send(3'd4, -1, 1'b0);
    new_packet();
    send(3'd1, -1, 1'b0);
    exp_toggle = ~exp_toggle;

    // STALL handshake
    new_packet();
`ifdef TX_STALL_EN
    send(3'd7, -1, 1'b0);
`else
    expect_reject(3'd7, 7'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
